// File: rtl/wb_exmem_master_if.sv
// Bundle of command, stream, status and Wishbone signals for the exmem initiator.
// The master modport is the initiator's view; slave is the user/responder side.
interface wb_exmem_master_if #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [BITS-1:0]  cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  logic [BITS-1:0]  wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [BITS-1:0]  rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [BITS-1:0]  wbm_adr_o;
  logic [BITS-1:0]  wbm_dat_o;
  logic [BITS-1:0]  wbm_dat_i;
  logic             wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_len, wr_data, wr_valid, rd_ready,
           wbm_dat_i, wbm_ack_i,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_len, wr_data, wr_valid, rd_ready,
           wbm_dat_i, wbm_ack_i,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_exmem_master.sv
// Wishbone classic initiator: one command becomes a run of single-beat read or write cycles,
// each beat bounded by an ack timeout, with valid/ready streams for write and read data.
module wb_exmem_master #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned TIMEOUT   = 32,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  wb_exmem_master_if.master   bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StWdat, StReq, StGap, StRdat} state_e;

  state_e           state_q;
  logic             cyc_q;
  logic             we_q;
  logic [BITS-1:0]  adr_q;
  logic [BITS-1:0]  dat_q;
  logic [BITS-1:0]  rd_data_q;
  logic [LEN_W-1:0] rem_q;
  logic [TmoW-1:0]  tmo_q;
  logic             done_q;
  logic             err_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rd_data_q <= '0;
      rem_q     <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            adr_q <= bus.cmd_adr;
            we_q  <= bus.cmd_we;
            rem_q <= bus.cmd_len;
            err_q <= 1'b0;
            if (bus.cmd_len == '0) begin
              done_q <= 1'b1;
            end else if (bus.cmd_we) begin
              state_q <= StWdat;
            end else begin
              state_q <= StReq;
              cyc_q   <= 1'b1;
              tmo_q   <= '0;
            end
          end
        end
        StWdat: begin
          if (bus.wr_valid) begin
            dat_q   <= bus.wr_data;
            state_q <= StReq;
            cyc_q   <= 1'b1;
            tmo_q   <= '0;
          end
        end
        StReq: begin
          // Ack wins over a timeout expiring in the same cycle.
          if (bus.wbm_ack_i) begin
            cyc_q <= 1'b0;
            if (we_q) begin
              rem_q   <= rem_q - LEN_W'(1);
              adr_q   <= adr_q + BITS'(ADDR_STEP);
              state_q <= StGap;
            end else begin
              rd_data_q <= bus.wbm_dat_i;
              state_q   <= StRdat;
            end
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            cyc_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StRdat: begin
          if (bus.rd_ready) begin
            rem_q   <= rem_q - LEN_W'(1);
            adr_q   <= adr_q + BITS'(ADDR_STEP);
            state_q <= StGap;
          end
        end
        StGap: begin
          if (rem_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (we_q) begin
            state_q <= StWdat;
          end else begin
            state_q <= StReq;
            cyc_q   <= 1'b1;
            tmo_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.wr_ready  = (state_q == StWdat) & bus.wr_valid;
  assign bus.rd_valid  = (state_q == StRdat);
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = cyc_q & we_q;
  assign bus.wbm_sel_o = {4{cyc_q}};
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_exmem_master.sv
// Scoreboard bench for wb_exmem_master: stimulus pushes expected beats, stb run lengths, read
// words and done/err outcomes; a negedge monitor pops and compares as the DUT presents them.
module tb_wb_exmem_master;

  localparam int unsigned TIMEOUT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_exmem_master_if #(.BITS(32), .LEN_W(8)) bus ();

  wb_exmem_master #(
    .BITS     (32),
    .LEN_W    (8),
    .TIMEOUT  (TIMEOUT),
    .ADDR_STEP(4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  beat_t       exp_bus[$];
  int          exp_run[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];

  int checks = 0;
  int errors = 0;

  // Responder: acks on the ack_at-th cycle of a strobe run unless ack_never is set.
  int          ack_at = 1;
  bit          ack_never = 1'b0;
  bit          force_ack = 1'b0;
  int          cnt = 0;
  int          rd_idx = 0;
  logic [31:0] resp_mem [0:3];

  initial begin
    resp_mem[0] = 32'hDEAD_BEEF;
    resp_mem[1] = 32'h1234_5678;
    resp_mem[2] = 32'h0;
    resp_mem[3] = 32'h0;
  end

  assign bus.wbm_ack_i = force_ack |
                         (bus.wbm_cyc_o & bus.wbm_stb_o & ~ack_never & (cnt == ack_at - 1));
  assign bus.wbm_dat_i = resp_mem[rd_idx[1:0]];

  always @(posedge clk) begin
    cnt <= bus.wbm_stb_o ? cnt + 1 : 0;
    if (bus.wbm_ack_i && bus.wbm_cyc_o && !bus.wbm_we_o) rd_idx <= rd_idx + 1;
  end

  function automatic void chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.done;
      1:       return bus.rd_valid;
      2:       return bus.wbm_cyc_o;
      3:       return bus.wr_ready;
      default: return bus.cmd_ready;
    endcase
  endfunction

  // Waits (bounded) until the selected signal is seen high at a negedge.
  task automatic wait_sig(input int which, input string nm);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sig(which)) return;
    end
    chk1(nm, 1'b0, 1'b1);
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [7:0] len);
    @(posedge clk); #1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    wait_sig(4, "cmd_accept_timeout");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_beat(input logic [31:0] d);
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
    wait_sig(3, "wr_ready_timeout");
    @(posedge clk); #1;
  endtask

  task automatic push_beat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input int run);
    beat_t b;
    b.we  = we;
    b.adr = adr;
    b.dat = dat;
    exp_bus.push_back(b);
    exp_run.push_back(run);
  endtask

  // Monitor
  initial begin
    int    run;
    beat_t b;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else begin
        if (bus.wbm_cyc_o) begin
          run++;
          chk1("stb_eq_cyc", bus.wbm_stb_o, 1'b1);
          chk32("sel_active", {28'h0, bus.wbm_sel_o}, 32'hF);
          if (bus.wbm_ack_i) begin
            if (exp_bus.size() == 0) begin
              chk1("beat_expected", 1'b0, 1'b1);
            end else begin
              b = exp_bus.pop_front();
              chk1("beat_we", bus.wbm_we_o, b.we);
              chk32("beat_adr", bus.wbm_adr_o, b.adr);
              if (b.we) chk32("beat_dat", bus.wbm_dat_o, b.dat);
            end
          end
        end else begin
          chk32("sel_idle", {28'h0, bus.wbm_sel_o}, 32'h0);
          if (run > 0) begin
            if (exp_run.size() == 0) chk1("run_expected", 1'b0, 1'b1);
            else chk32("stb_run_len", run, exp_run.pop_front());
            run = 0;
          end
        end
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_rd.size() == 0) chk1("rd_expected", 1'b0, 1'b1);
          else chk32("rd_data", bus.rd_data, exp_rd.pop_front());
        end
        if (bus.done) begin
          if (exp_done.size() == 0) chk1("done_expected", 1'b0, 1'b1);
          else chk1("done_err", bus.err, exp_done.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk1("rst_cyc", bus.wbm_cyc_o, 1'b0);
    chk1("rst_rd_valid", bus.rd_valid, 1'b0);
    chk32("rst_adr", bus.wbm_adr_o, 32'h0);
    chk32("rst_rd_data", bus.rd_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: three-beat write, ack on 11th strobe cycle
    ack_at = 11;
    push_beat(1'b1, 32'h3800_0000, 32'hA1, 11);
    push_beat(1'b1, 32'h3800_0004, 32'hB2, 11);
    push_beat(1'b1, 32'h3800_0008, 32'hC3, 11);
    exp_done.push_back(1'b0);
    issue(1'b1, 32'h3800_0000, 8'd3);
    write_beat(32'hA1);
    write_beat(32'hB2);
    write_beat(32'hC3);
    bus.wr_valid = 1'b0;
    wait_sig(0, "t1_done_timeout");
    chk1("t1_err", bus.err, 1'b0);

    // 2: two-beat read with back-pressure on the first word
    ack_at = 3;
    bus.rd_ready = 1'b0;
    push_beat(1'b0, 32'h3800_0004, 32'h0, 3);
    push_beat(1'b0, 32'h3800_0008, 32'h0, 3);
    exp_rd.push_back(32'hDEAD_BEEF);
    exp_rd.push_back(32'h1234_5678);
    exp_done.push_back(1'b0);
    issue(1'b0, 32'h3800_0004, 8'd2);
    wait_sig(1, "t2_rd_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      chk32("t2_rd_stable", bus.rd_data, 32'hDEAD_BEEF);
      chk1("t2_rd_valid_held", bus.rd_valid, 1'b1);
      chk1("t2_no_stb", bus.wbm_stb_o, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rd_ready = 1'b1;
    wait_sig(0, "t2_done_timeout");

    // 3: read with no ack -> timeout
    ack_never = 1'b1;
    exp_run.push_back(TIMEOUT);
    exp_done.push_back(1'b1);
    issue(1'b0, 32'h3800_0000, 8'd4);
    wait_sig(0, "t3_done_timeout");
    chk1("t3_err", bus.err, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("t3_no_more_cyc", bus.wbm_cyc_o, 1'b0);
    end
    chk1("t3_err_sticky", bus.err, 1'b1);
    ack_never = 1'b0;

    // 4: zero-length command (also clears err)
    exp_done.push_back(1'b0);
    issue(1'b0, 32'h3800_0000, 8'd0);
    @(negedge clk);
    chk1("t4_done", bus.done, 1'b1);
    chk1("t4_err_cleared", bus.err, 1'b0);
    chk1("t4_busy", bus.busy, 1'b0);
    chk1("t4_cyc", bus.wbm_cyc_o, 1'b0);
    @(negedge clk);
    chk1("t4_done_pulse", bus.done, 1'b0);
    chk1("t4_busy2", bus.busy, 1'b0);

    // 5: reset in the middle of a write beat
    ack_at = 20;
    issue(1'b1, 32'h3800_0000, 8'd3);
    write_beat(32'h1111_1111);
    bus.wr_valid = 1'b0;
    wait_sig(2, "t5_cyc_timeout");
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk1("t5_cyc_async", bus.wbm_cyc_o, 1'b0);
    chk1("t5_stb_async", bus.wbm_stb_o, 1'b0);
    chk32("t5_sel_async", {28'h0, bus.wbm_sel_o}, 32'h0);
    chk1("t5_cmd_ready_rst", bus.cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b1;
    @(negedge clk);
    chk1("t5_late_ack_cyc", bus.wbm_cyc_o, 1'b0);
    chk1("t5_late_ack_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk1("t5_busy", bus.busy, 1'b0);
    chk1("t5_done", bus.done, 1'b0);

    // 6: address wrap, ack coincident with timeout expiry
    ack_at = TIMEOUT;
    push_beat(1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, TIMEOUT);
    push_beat(1'b1, 32'h0000_0000, 32'h0F0F_0F0F, TIMEOUT);
    exp_done.push_back(1'b0);
    issue(1'b1, 32'hFFFF_FFFC, 8'd2);
    write_beat(32'h5555_AAAA);
    write_beat(32'h0F0F_0F0F);
    bus.wr_valid = 1'b0;
    wait_sig(0, "t6_done_timeout");
    chk1("t6_err", bus.err, 1'b0);

    repeat (3) @(negedge clk);
    chk32("left_beats", exp_bus.size(), 32'd0);
    chk32("left_runs", exp_run.size(), 32'd0);
    chk32("left_rd", exp_rd.size(), 32'd0);
    chk32("left_done", exp_done.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
